// File: rtl/debug_reg_ctrl.sv
// Debug access controller: halts the core, reaches the register file through the
// coprocessor IO port and returns one response per accepted host command.
module debug_reg_ctrl #(
    parameter int unsigned N       = 64,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    // host command channel
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [1:0]   cmd_op_i,
    input  logic [4:0]   cmd_addr_i,
    input  logic [N-1:0] cmd_wdata_i,
    // host response channel
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [N-1:0] rsp_data_o,
    output logic         rsp_err_o,
    // core control
    output logic         core_stall_o,
    input  logic         core_idle_i,
    output logic         halted_o,
    // coprocessor IO port
    output logic [14:0]  dbg_addr_o,
    output logic [2:0]   dbg_ctrl_o,
    output logic [N-1:0] dbg_wdata_o,
    input  logic [N-1:0] dbg_rdata_i
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    localparam logic [1:0] OpHalt   = 2'b00;
    localparam logic [1:0] OpResume = 2'b01;
    localparam logic [1:0] OpRead   = 2'b10;
    localparam logic [1:0] OpWrite  = 2'b11;

    typedef enum logic [2:0] {
        StRun,
        StHaltWait,
        StHalted,
        StAccess,
        StResp
    } state_e;

    state_e          state_q;
    logic            ret_halted_q;  // state to resume after the response is taken
    logic [CntW-1:0] cnt_q;
    logic            stall_q;
    logic            halted_q;
    logic            rsp_valid_q;
    logic [N-1:0]    rsp_data_q;
    logic            rsp_err_q;
    logic [4:0]      dbg_addr_q;
    logic            dbg_we_q;
    logic            dbg_re_q;
    logic [N-1:0]    dbg_wdata_q;

    logic accept;

    // Commands are taken only in the two resting states; RESP blocks new commands.
    always_comb begin
        cmd_ready_o = (state_q == StRun) || (state_q == StHalted);
        accept      = cmd_valid_i && cmd_ready_o;
    end

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StRun;
            ret_halted_q <= 1'b0;
            cnt_q        <= '0;
            stall_q      <= 1'b0;
            halted_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            dbg_addr_q   <= '0;
            dbg_we_q     <= 1'b0;
            dbg_re_q     <= 1'b0;
            dbg_wdata_q  <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (accept) begin
                        if (cmd_op_i == OpHalt) begin
                            state_q <= StHaltWait;
                            stall_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            // Resume is a no-op; register access is refused while running.
                            state_q      <= StResp;
                            ret_halted_q <= 1'b0;
                            rsp_valid_q  <= 1'b1;
                            rsp_data_q   <= '0;
                            rsp_err_q    <= (cmd_op_i == OpRead) || (cmd_op_i == OpWrite);
                        end
                    end
                end

                StHaltWait: begin
                    if (core_idle_i) begin
                        state_q      <= StResp;
                        ret_halted_q <= 1'b1;
                        halted_q     <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= '0;
                        rsp_err_q    <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        // Core never drained: release it and report failure.
                        state_q      <= StResp;
                        ret_halted_q <= 1'b0;
                        stall_q      <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= '0;
                        rsp_err_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StHalted: begin
                    if (accept) begin
                        unique case (cmd_op_i)
                            OpHalt: begin
                                state_q      <= StResp;
                                ret_halted_q <= 1'b1;
                                rsp_valid_q  <= 1'b1;
                                rsp_data_q   <= '0;
                                rsp_err_q    <= 1'b0;
                            end
                            OpResume: begin
                                state_q      <= StResp;
                                ret_halted_q <= 1'b0;
                                stall_q      <= 1'b0;
                                halted_q     <= 1'b0;
                                rsp_valid_q  <= 1'b1;
                                rsp_data_q   <= '0;
                                rsp_err_q    <= 1'b0;
                            end
                            OpRead: begin
                                state_q    <= StAccess;
                                dbg_addr_q <= cmd_addr_i;
                                dbg_re_q   <= 1'b1;
                            end
                            default: begin
                                state_q     <= StAccess;
                                dbg_addr_q  <= cmd_addr_i;
                                dbg_we_q    <= 1'b1;
                                dbg_wdata_q <= cmd_wdata_i;
                            end
                        endcase
                    end
                end

                StAccess: begin
                    // Single-cycle port access; the register file commits or answers now.
                    state_q      <= StResp;
                    ret_halted_q <= 1'b1;
                    rsp_valid_q  <= 1'b1;
                    rsp_err_q    <= 1'b0;
                    rsp_data_q   <= (dbg_re_q && (dbg_addr_q != 5'd0)) ? dbg_rdata_i : '0;
                    dbg_addr_q   <= '0;
                    dbg_we_q     <= 1'b0;
                    dbg_re_q     <= 1'b0;
                    dbg_wdata_q  <= '0;
                end

                StResp: begin
                    if (rsp_ready_i) begin
                        state_q     <= ret_halted_q ? StHalted : StRun;
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    // Output wiring from the registered state.
    always_comb begin
        rsp_valid_o  = rsp_valid_q;
        rsp_data_o   = rsp_data_q;
        rsp_err_o    = rsp_err_q;
        core_stall_o = stall_q;
        halted_o     = halted_q;
        dbg_addr_o   = {10'b0, dbg_addr_q};
        dbg_ctrl_o   = {halted_q, dbg_re_q, dbg_we_q};
        dbg_wdata_o  = dbg_wdata_q;
    end

    // Debug write must never overlap core register writes.
    a_we_only_halted : assert property (
        @(posedge clk_i) disable iff (!rst_ni) dbg_we_q |-> halted_q);

    // Port strobes are confined to the access cycle.
    a_strobe_in_access : assert property (
        @(posedge clk_i) disable iff (!rst_ni) (dbg_we_q || dbg_re_q) |-> (state_q == StAccess));

endmodule

// File: tb/tb_debug_reg_ctrl.sv
// Self-checking bench for debug_reg_ctrl: directed scenarios plus random traffic,
// compared every cycle against a transaction-level behavioural model.
module tb_debug_reg_ctrl;

    localparam int unsigned N       = 64;
    localparam int unsigned TIMEOUT = 16;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [4:0]   cmd_addr;
    logic [N-1:0] cmd_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_err;
    logic         core_stall;
    logic         core_idle;
    logic         halted;
    logic [14:0]  dbg_addr;
    logic [2:0]   dbg_ctrl;
    logic [N-1:0] dbg_wdata;
    logic [N-1:0] dbg_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk_i = ~clk_i;

    debug_reg_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .core_stall_o(core_stall),
        .core_idle_i (core_idle),
        .halted_o    (halted),
        .dbg_addr_o  (dbg_addr),
        .dbg_ctrl_o  (dbg_ctrl),
        .dbg_wdata_o (dbg_wdata),
        .dbg_rdata_i (dbg_rdata)
    );

    // Environment register file behind the coprocessor port (x0 hardwired to 0).
    logic [N-1:0] env_rf [32] = '{default: '0};
    assign dbg_rdata = (dbg_addr[4:0] == 5'd0) ? '0 : env_rf[dbg_addr[4:0]];
    always @(posedge clk_i) begin
        if (dbg_ctrl[0] && dbg_addr[4:0] != 5'd0) env_rf[dbg_addr[4:0]] <= dbg_wdata;
    end

    // Behavioural model: what the controller is doing, in transaction terms.
    bit           m_halted, m_stall;
    bit           m_waiting;
    int           m_wait_n;
    bit           m_acc, m_acc_read;
    logic [4:0]   m_acc_addr;
    logic [N-1:0] m_acc_wdata;
    bit           m_rsp, m_rsp_err;
    logic [N-1:0] m_rsp_data;
    logic [N-1:0] m_rf [32] = '{default: '0};

    task automatic model_reset();
        m_halted = 0; m_stall = 0; m_waiting = 0; m_wait_n = 0;
        m_acc = 0; m_acc_read = 0; m_acc_addr = '0; m_acc_wdata = '0;
        m_rsp = 0; m_rsp_err = 0; m_rsp_data = '0;
    endtask

    task automatic respond(input bit err, input logic [N-1:0] data);
        m_rsp = 1; m_rsp_err = err; m_rsp_data = data;
    endtask

    // Advance the model by one clock using the inputs the DUT sees on that edge.
    task automatic model_step();
        bit busy;
        busy = m_waiting || m_acc || m_rsp;
        if (m_rsp) begin
            if (rsp_ready) begin
                m_rsp = 0; m_rsp_err = 0; m_rsp_data = '0;
            end
        end else if (m_acc) begin
            if (m_acc_read) respond(0, m_rf[m_acc_addr]);
            else begin
                if (m_acc_addr != 5'd0) m_rf[m_acc_addr] = m_acc_wdata;
                respond(0, '0);
            end
            m_acc = 0;
        end else if (m_waiting) begin
            if (core_idle) begin
                m_halted = 1; m_waiting = 0; respond(0, '0);
            end else if (m_wait_n == TIMEOUT - 1) begin
                m_stall = 0; m_waiting = 0; respond(1, '0);
            end else begin
                m_wait_n++;
            end
        end else if (cmd_valid && !busy) begin
            case (cmd_op)
                2'b00: if (m_halted) respond(0, '0);
                       else begin m_waiting = 1; m_wait_n = 0; m_stall = 1; end
                2'b01: begin
                    if (m_halted) begin m_halted = 0; m_stall = 0; end
                    respond(0, '0);
                end
                default: begin
                    if (!m_halted) respond(1, '0);
                    else begin
                        m_acc = 1; m_acc_read = (cmd_op == 2'b10);
                        m_acc_addr = cmd_addr;
                        m_acc_wdata = cmd_wdata;
                    end
                end
            endcase
        end
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("cmd_ready", cmd_ready, !(m_waiting || m_acc || m_rsp));
            check("core_stall", core_stall, m_stall);
            check("halted", halted, m_halted);
            check("rsp_valid", rsp_valid, m_rsp);
            check("rsp_err", rsp_err, m_rsp ? m_rsp_err : 1'b0);
            check("rsp_data", rsp_data, m_rsp ? m_rsp_data : '0);
            check("dbg_ctrl", dbg_ctrl, {m_halted, m_acc && m_acc_read, m_acc && !m_acc_read});
            check("dbg_addr", dbg_addr, m_acc ? {10'b0, m_acc_addr} : 15'd0);
            check("dbg_wdata", dbg_wdata, (m_acc && !m_acc_read) ? m_acc_wdata : '0);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        if (rst_ni) model_step();
        @(negedge clk_i);
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] addr, input logic [N-1:0] wd);
        cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        tick();
        cmd_valid = 0; cmd_op = $urandom_range(0, 3); cmd_addr = $urandom_range(0, 31);
        cmd_wdata = {$urandom, $urandom};
    endtask

    // Pulse reset off-edge, leaving the bench 2 ns after a falling edge.
    task automatic do_reset();
        cmd_valid = 0;
        #2 rst_ni = 0;
        model_reset();
        @(negedge clk_i);
        #2 rst_ni = 1;
    endtask

    int idle_pct;

    initial begin
        rst_ni = 0; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wdata = '0;
        rsp_ready = 1; core_idle = 1;
        model_reset();
        @(negedge clk_i);
        chk_en = 1;
        #2 rst_ni = 1;
        tick();

        // Reset state
        check("t1_ready", cmd_ready, 1'b1);
        check("t1_stall", core_stall, 1'b0);
        check("t1_halted", halted, 1'b0);
        check("t1_rsp_valid", rsp_valid, 1'b0);
        check("t1_dbg_ctrl", dbg_ctrl, 3'b000);

        // Halt with an idle core
        send(2'b00, 5'd0, '0);
        check("t2_stall", core_stall, 1'b1);
        check("t2_rsp_early", rsp_valid, 1'b0);
        tick();
        check("t2_rsp_valid", rsp_valid, 1'b1);
        check("t2_err", rsp_err, 1'b0);
        check("t2_halted", halted, 1'b1);
        check("t2_dbg_ctrl", dbg_ctrl, 3'b100);
        tick();
        check("t2_ready", cmd_ready, 1'b1);

        // Write then read x5, read x0
        send(2'b11, 5'd5, 64'hDEAD_BEEF);
        check("t4_wr_ctrl", dbg_ctrl, 3'b101);
        check("t4_wr_addr", dbg_addr, 15'd5);
        check("t4_wr_data", dbg_wdata, 64'hDEAD_BEEF);
        tick();
        check("t4_wr_rsp", rsp_valid, 1'b1);
        check("t4_wr_err", rsp_err, 1'b0);
        check("t4_wr_idle", dbg_ctrl, 3'b100);
        tick();
        send(2'b10, 5'd5, '0);
        check("t4_rd_ctrl", dbg_ctrl, 3'b110);
        tick();
        check("t4_rd_data", rsp_data, 64'hDEAD_BEEF);
        check("t4_rd_err", rsp_err, 1'b0);
        tick();
        send(2'b10, 5'd0, '0);
        tick();
        check("t4_x0_valid", rsp_valid, 1'b1);
        check("t4_x0_data", rsp_data, 64'h0);
        tick();

        // Resume, then read while running
        send(2'b01, 5'd0, '0);
        check("t5_resume_rsp", rsp_valid, 1'b1);
        check("t5_resume_stall", core_stall, 1'b0);
        check("t5_resume_halted", halted, 1'b0);
        tick();
        send(2'b10, 5'd3, '0);
        check("t5_run_rd_ctrl", dbg_ctrl, 3'b000);
        check("t5_run_rd_rsp", rsp_valid, 1'b1);
        check("t5_run_rd_err", rsp_err, 1'b1);
        check("t5_run_rd_data", rsp_data, 64'h0);
        tick();

        // Halt timeout with a busy core
        core_idle = 0;
        send(2'b00, 5'd0, '0);
        repeat (TIMEOUT - 1) tick();
        check("t3_still_wait", rsp_valid, 1'b0);
        check("t3_still_stall", core_stall, 1'b1);
        tick();
        check("t3_to_rsp", rsp_valid, 1'b1);
        check("t3_to_err", rsp_err, 1'b1);
        check("t3_to_stall", core_stall, 1'b0);
        check("t3_to_halted", halted, 1'b0);
        tick();
        check("t3_ready", cmd_ready, 1'b1);

        // Back-pressure then reset mid-response
        core_idle = 1;
        send(2'b00, 5'd0, '0);
        tick();
        tick();
        rsp_ready = 0;
        send(2'b10, 5'd5, '0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t6_hold_valid", rsp_valid, 1'b1);
            check("t6_hold_data", rsp_data, 64'hDEAD_BEEF);
            check("t6_hold_ready", cmd_ready, 1'b0);
            tick();
        end
        #2 rst_ni = 0;
        model_reset();
        #1;
        check("t6_rst_valid", rsp_valid, 1'b0);
        check("t6_rst_stall", core_stall, 1'b0);
        check("t6_rst_halted", halted, 1'b0);
        check("t6_rst_ready", cmd_ready, 1'b1);
        check("t6_rst_ctrl", dbg_ctrl, 3'b000);
        @(negedge clk_i);
        #2 rst_ni = 1;
        rsp_ready = 1;

        // Random traffic
        idle_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: idle_pct = 3;
                    1: idle_pct = 30;
                    default: idle_pct = 90;
                endcase
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_op    = $urandom_range(0, 3);
            cmd_addr  = $urandom_range(0, 7);
            cmd_wdata = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 3) != 0);
            core_idle = ($urandom_range(0, 99) < idle_pct);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
